// File: rtl/frame_cfg_pkg.sv
// Shared types and header field layout for the column configuration sequencer.
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam int IDX_LSB    = 0;
  localparam int IDX_W      = 5;
  localparam int DESYNC_BIT = 30;
  localparam int LAST_BIT   = 31;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Frame index to one-hot strobe vector plus out-of-range flag.
// Purely combinational; the caller registers the result.
module frame_strobe_decoder
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20
) (
  input  logic [IDX_W-1:0]           idx,
  output logic [MaxFramesPerCol-1:0] onehot,
  output logic                       out_of_range
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      onehot[i] = (32'(idx) == i);
    end
    out_of_range = (32'(idx) >= MaxFramesPerCol);
  end

endmodule

// File: rtl/frame_config_sequencer.sv
// Sync/header/row staging into one column's FrameData and one-hot FrameStrobe; FRAME_CFG_CHECKSUM_EN adds a checksum word per frame.
// FrameData updates the cycle after the last word, FrameStrobe the cycle after that; s_ready is low through SETUP/STROBE/HOLD.
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int                         FrameBitsPerRow = 32,
  parameter int                         MaxFramesPerCol = 20,
  parameter int                         NumRows         = 4,
  parameter int                         StrobeCycles    = 1,
  parameter logic [FrameBitsPerRow-1:0] SyncWord        = FrameBitsPerRow'(SYNC_WORD_DEFAULT)
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  input  logic [FrameBitsPerRow-1:0]           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 err,
  input  logic                                 clear_err,
  output logic [15:0]                          frames_done
);

`ifdef FRAME_CFG_CHECKSUM_EN
  localparam int LoadWords = NumRows + 1;
`else
  localparam int LoadWords = NumRows;
`endif
  localparam int RW = $clog2(LoadWords + 1);

  state_t                               state, next_state;
  logic [RW-1:0]                        row;
  logic [NumRows*FrameBitsPerRow-1:0]   staging, staged_next;
  logic [MaxFramesPerCol-1:0]           strobe_sel, dec_onehot;
  logic                                 dec_oor;
  logic                                 bad_idx, last;
  logic [3:0]                           scnt;
  logic                                 accept, load_done, csum_ok, err_set;

  assign accept = s_valid && s_ready;
  assign busy   = (state != IDLE);

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_dec (
    .idx          (s_data[IDX_LSB +: IDX_W]),
    .onehot       (dec_onehot),
    .out_of_range (dec_oor)
  );

`ifdef FRAME_CFG_CHECKSUM_EN
  // Running mod-2^32 sum of header plus data words, compared against the trailing word.
  logic [FrameBitsPerRow-1:0] csum;
  assign csum_ok = (s_data == csum);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      csum <= '0;
    end else if (state == HDR && accept) begin
      csum <= s_data;
    end else if (state == LOAD && accept) begin
      csum <= csum + s_data;
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  assign load_done = (state == LOAD) && accept && (row == RW'(LoadWords - 1));

  always_comb begin
    staged_next = staging;
    if (state == LOAD && accept && int'(row) < NumRows) begin
      staged_next[int'(row)*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
    end
  end

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && s_data == SyncWord) next_state = HDR;
      end
      HDR: begin
        // A repeated sync word is tolerated; it also has the desync bit set, so test it first.
        if (accept && s_data != SyncWord) begin
          if (s_data[DESYNC_BIT]) begin
            next_state = IDLE;
          end else begin
            next_state = LOAD;
            err_set    = dec_oor;
          end
        end
      end
      LOAD: begin
        if (load_done) begin
          if (bad_idx || !csum_ok) begin
            next_state = last ? IDLE : HDR;
            err_set    = !csum_ok;
          end else begin
            next_state = SETUP;
          end
        end
      end
      SETUP:   next_state = STROBE;
      STROBE: begin
        if (scnt == 4'(StrobeCycles - 1)) next_state = HOLD;
      end
      HOLD:    next_state = last ? IDLE : HDR;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      s_ready     <= 1'b0;
      row         <= '0;
      staging     <= '0;
      strobe_sel  <= '0;
      bad_idx     <= 1'b0;
      last        <= 1'b0;
      scnt        <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      frames_done <= '0;
      err         <= 1'b0;
    end else begin
      state   <= next_state;
      s_ready <= (next_state == IDLE) || (next_state == HDR) || (next_state == LOAD);

      if (state == HDR && next_state == LOAD) begin
        row        <= '0;
        strobe_sel <= dec_onehot;
        bad_idx    <= dec_oor;
        last       <= s_data[LAST_BIT];
      end else if (state == LOAD && accept) begin
        row     <= row + 1'b1;
        staging <= staged_next;
      end

      // Outputs are aligned with the state they belong to: data during SETUP, strobe during STROBE.
      if (state == LOAD && next_state == SETUP) FrameData <= staged_next;
      FrameStrobe <= (next_state == STROBE) ? strobe_sel : '0;

      scnt <= (state == STROBE) ? scnt + 4'd1 : 4'd0;
      if (state == HOLD) frames_done <= frames_done + 16'd1;

      if (err_set)        err <= 1'b1;
      else if (clear_err) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed self-checking bench for frame_config_sequencer (checksum cases when FRAME_CFG_CHECKSUM_EN is defined).
module tb_frame_config_sequencer;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic         CLK = 1'b0;
  logic         resetn = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy;
  logic         err;
  logic         clear_err = 1'b0;
  logic [15:0]  frames_done;

  int total = 0;
  int bad   = 0;

  frame_config_sequencer dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err),
    .clear_err   (clear_err),
    .frames_done (frames_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents one word and returns 1 time unit after the edge that accepted it.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (s_ready !== 1'b1) chk("send_timeout", {127'b0, s_ready}, 128'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [31:0] sum);
`ifdef FRAME_CFG_CHECKSUM_EN
    send(sum);
`else
    if (sum == 32'hFFFF_FFFF) s_data = sum;
`endif
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    send(hdr);
    send(d0);
    send(d1);
    send(d2);
    send(d3);
    send_csum(hdr + d0 + d1 + d2 + d3);
  endtask

  initial begin
    logic [127:0] fd_b;

    #1;
    chk("rst_ready",  {127'b0, s_ready}, 128'd0);
    chk("rst_strobe", {108'b0, FrameStrobe}, 128'd0);
    chk("rst_data",   FrameData, 128'd0);
    chk("rst_err",    {127'b0, err}, 128'd0);
    chk("rst_done",   {112'b0, frames_done}, 128'd0);
    chk("rst_busy",   {127'b0, busy}, 128'd0);
    step();
    resetn = 1'b1;
    step();
    chk("ready_after_rst", {127'b0, s_ready}, 128'd1);

    // Frame to index 3
    send(SYNC);
    chk("sync_busy", {127'b0, busy}, 128'd1);
    send_frame(32'h0000_0003, 32'h1111_00A0, 32'h2222_00A1, 32'h3333_00A2, 32'h4444_00A3);
    chk("f0_setup_data", FrameData, {32'h4444_00A3, 32'h3333_00A2, 32'h2222_00A1, 32'h1111_00A0});
    chk("f0_setup_strobe", {108'b0, FrameStrobe}, 128'd0);
    chk("f0_setup_ready", {127'b0, s_ready}, 128'd0);
    step();
    chk("f0_strobe", {108'b0, FrameStrobe}, 128'h0_0008);
    step();
    chk("f0_hold_strobe", {108'b0, FrameStrobe}, 128'd0);
    step();
    chk("f0_done", {112'b0, frames_done}, 128'd1);
    chk("f0_hdr_busy", {127'b0, busy}, 128'd1);
    chk("f0_hdr_ready", {127'b0, s_ready}, 128'd1);

    // Last-index frame with last flag
    send_frame(32'h8000_0013, 32'hB0B0_0000, 32'hB1B1_0001, 32'hB2B2_0002, 32'hB3B3_0003);
    fd_b = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};
    chk("f1_data", FrameData, fd_b);
    step();
    chk("f1_strobe", {108'b0, FrameStrobe}, 128'h8_0000);
    step();
    step();
    chk("f1_idle_busy", {127'b0, busy}, 128'd0);
    chk("f1_done", {112'b0, frames_done}, 128'd2);

    // Out-of-range index: words consumed, no strobe
    send(SYNC);
    send(32'h0000_0014);
    chk("oor_err", {127'b0, err}, 128'd1);
    send(32'hDEAD_0000);
    send(32'hDEAD_0001);
    send(32'hDEAD_0002);
    send(32'hDEAD_0003);
    send_csum(32'h0000_0014 + 32'hDEAD_0000 + 32'hDEAD_0001 + 32'hDEAD_0002 + 32'hDEAD_0003);
    chk("oor_ready", {127'b0, s_ready}, 128'd1);
    step();
    chk("oor_strobe", {108'b0, FrameStrobe}, 128'd0);
    chk("oor_data", FrameData, fd_b);
    chk("oor_done", {112'b0, frames_done}, 128'd2);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clear_err", {127'b0, err}, 128'd0);
    // Set and clear in the same cycle: set wins
    clear_err = 1'b1;
    send(32'h0000_001F);
    clear_err = 1'b0;
    chk("set_beats_clear", {127'b0, err}, 128'd1);
    send(32'h1);
    send(32'h2);
    send(32'h3);
    send(32'h4);
    send_csum(32'h0000_001F + 32'h1 + 32'h2 + 32'h3 + 32'h4);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;

    // Sync word as header is ignored; desync returns to IDLE
    send(SYNC);
    chk("sync_in_hdr_busy", {127'b0, busy}, 128'd1);
    chk("sync_in_hdr_ready", {127'b0, s_ready}, 128'd1);
    send(32'h4000_0000);
    chk("desync_idle", {127'b0, busy}, 128'd0);
    send(32'h0000_0003);
    chk("idle_discard", {127'b0, busy}, 128'd0);
    chk("desync_strobe", {108'b0, FrameStrobe}, 128'd0);
    chk("desync_done", {112'b0, frames_done}, 128'd2);

`ifdef FRAME_CFG_CHECKSUM_EN
    send(SYNC);
    send_frame(32'h0000_0005, 32'h10, 32'h20, 32'h30, 32'h40);
    step();
    chk("csum_ok_strobe", {108'b0, FrameStrobe}, 128'h0_0020);
    step();
    step();
    chk("csum_ok_done", {112'b0, frames_done}, 128'd3);
    send(32'h8000_0006);
    send(32'h10);
    send(32'h20);
    send(32'h30);
    send(32'h40);
    send(32'h8000_0006 + 32'h10 + 32'h20 + 32'h30 + 32'h40 + 32'h1);
    chk("csum_bad_err", {127'b0, err}, 128'd1);
    chk("csum_bad_idle", {127'b0, busy}, 128'd0);
    step();
    chk("csum_bad_strobe", {108'b0, FrameStrobe}, 128'd0);
    chk("csum_bad_done", {112'b0, frames_done}, 128'd3);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
`endif

    // Stall mid-LOAD, then reset during STROBE
    send(SYNC);
    send(32'h0000_0000);
    send(32'hC0C0_0000);
    send(32'hC1C1_0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_strobe", {108'b0, FrameStrobe}, 128'd0);
    end
    chk("stall_data", FrameData, fd_b);
    chk("stall_ready", {127'b0, s_ready}, 128'd1);
    send(32'hC2C2_0002);
    send(32'hC3C3_0003);
    send_csum(32'h0 + 32'hC0C0_0000 + 32'hC1C1_0001 + 32'hC2C2_0002 + 32'hC3C3_0003);
    chk("stall_data_done", FrameData, {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000});
    step();
    chk("stall_strobe_on", {108'b0, FrameStrobe}, 128'h0_0001);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_strobe", {108'b0, FrameStrobe}, 128'd0);
    chk("rst_mid_done", {112'b0, frames_done}, 128'd0);
    chk("rst_mid_busy", {127'b0, busy}, 128'd0);
    chk("rst_mid_ready", {127'b0, s_ready}, 128'd0);
    step();
    resetn = 1'b1;
    step();
    chk("rst_mid_ready_after", {127'b0, s_ready}, 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_config_sequencer.md
Name: frame_config_sequencer

Overview:
- Streams configuration frames into one tile column by driving FrameData (all rows) and a one-hot FrameStrobe pulse, so the column's ConfigMem latches capture each frame.
- Sits between the bitstream source (SPI/UART config port) and the column's FrameData/FrameStrobe inputs at the fabric top.
- Provides sync detection, header parsing, per-row word staging, and setup/strobe/hold sequencing, with sticky error reporting.

Parameters:
- FrameBitsPerRow, 32, width of one row's FrameData slice and of the input word.
- MaxFramesPerCol, 20, FrameStrobe width; valid frame indices are 0..MaxFramesPerCol-1.
- NumRows, 4, tiles per column; each frame carries this many data words.
- StrobeCycles, 1, cycles FrameStrobe stays asserted (range 1..15).
- SyncWord, 32'hFAB0_FAB1, word that starts a configuration session.

Ports:
- CLK  in  1  configuration clock.
- resetn  in  1  asynchronous active-low reset.
- s_data  in  FrameBitsPerRow  input word stream.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid&&s_ready.
- FrameData  out  NumRows*FrameBitsPerRow  column frame data; row r drives bits [r*32+31:r*32].
- FrameStrobe  out  MaxFramesPerCol  one-hot frame strobe.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky error.
- clear_err  in  1  synchronous clear of err.
- frames_done  out  16  count of strobed frames; wraps at 0xFFFF->0.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; FrameData=0; FrameStrobe=0; s_ready=0 during reset, then 1; err=0; frames_done=0; row counter=0.
- States: IDLE -> HDR -> LOAD -> SETUP -> STROBE -> HOLD -> HDR/IDLE.
- s_ready: 1 in IDLE, HDR and LOAD; 0 in SETUP, STROBE and HOLD.
- IDLE: discard every accepted word except SyncWord. SyncWord moves to HDR.
- HDR: accepted word is the header. Fields:
  - [4:0] frame index.
  - [30] desync: go to IDLE, no frame written.
  - [31] last: return to IDLE after this frame's HOLD.
  - A header equal to SyncWord is ignored; state stays HDR.
  - Otherwise go to LOAD with row=0.
- LOAD: accepted words fill the staging register at row 0..NumRows-1, row incrementing per word. The word for row NumRows-1 moves to SETUP. FrameData is unchanged in LOAD.
- SETUP (1 cycle): FrameData <= staging; FrameStrobe=0.
- STROBE (StrobeCycles cycles): FrameStrobe[index]=1, all other bits 0; FrameData held.
- HOLD (1 cycle): FrameStrobe=0; FrameData held; frames_done increments. Next state is IDLE if last=1, else HDR.
- Frame index >= MaxFramesPerCol:
  - err set in the cycle the header is accepted.
  - Data words are still consumed.
  - SETUP/STROBE/HOLD are skipped; FrameData is unchanged; frames_done is not incremented.
  - Next state is HDR, or IDLE if last=1.
- err: sticky. If clear_err and a new error occur in the same cycle, the set wins.
- Minimum latency from last data word accepted to first FrameStrobe edge: 2 cycles. Frame-to-frame minimum period: NumRows+1 words plus StrobeCycles+2 cycles.
- s_valid low mid-LOAD: stall with no timeout; the staging register keeps its partial contents.
- Reset mid-STROBE: FrameStrobe drops to 0 asynchronously; the partial frame is lost.

Optional Feature:
- Macro: FRAME_CFG_CHECKSUM_EN.
- With the macro: after the last data word, LOAD accepts one extra checksum word. It must equal the mod-2^32 sum of the header and all NumRows data words.
  - Match: continue to SETUP.
  - Mismatch: set err, skip SETUP/STROBE/HOLD, leave FrameData unchanged, go to HDR (or IDLE if last=1).
- Without the macro: no checksum word; LOAD ends after NumRows data words.

Decomposition:
- Package frame_cfg_pkg:
  - state enum (IDLE, HDR, LOAD, SETUP, STROBE, HOLD).
  - header bit positions (IDX_LSB=0, IDX_W=5, DESYNC_BIT=30, LAST_BIT=31).
  - SYNC_WORD_DEFAULT constant.
- Sub-module frame_strobe_decoder: converts the frame index to a one-hot MaxFramesPerCol vector and outputs an out-of-range flag. It is purely combinational; the top level registers its output.

Test Plan:
- Sync then header 0x0000_0003, data {A0,A1,A2,A3} -> FrameData={A3,A2,A1,A0} one cycle before FrameStrobe=0x00008 for 1 cycle; frames_done=1; state HDR.
- Header 0x8000_0013 (index 19, last) -> FrameStrobe=0x80000; then busy=0, state IDLE.
- Header 0x0000_0014 (index 20) -> err=1; 4 words consumed; FrameStrobe stays 0; frames_done unchanged; clear_err -> err=0.
- Header 0x4000_0000 -> IDLE, no strobe; SyncWord sent in HDR -> ignored, still HDR.
- s_valid deasserted for 5 cycles after the second data word -> no strobe until the remaining words arrive; resetn low during STROBE -> FrameStrobe=0 immediately, frames_done=0.
- With FRAME_CFG_CHECKSUM_EN: correct sum -> strobe; sum+1 -> err=1, no strobe.
